// File: rtl/lives_pkg.sv
// Shared types and widths for the player lives controller.
package lives_pkg;

  localparam int LIVES_W     = 2;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    ALIVE,
    INVULN,
    GAME_OVER
  } lives_state_t;

endpackage

// File: rtl/frame_timer.sv
// Loadable down counter stepped once per video frame; saturates at zero.
module frame_timer
  import lives_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [FRAME_CNT_W-1:0] load_val,
  input  logic                   dec,
  output logic [FRAME_CNT_W-1:0] count,
  output logic                   zero,
  output logic                   last
);

  logic [FRAME_CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);
  assign last  = (cnt_q == FRAME_CNT_W'(1));

endmodule

// File: rtl/lives_controller.sv
// Player life counter with frame-timed invulnerability window, HUD blink and game-over flag.
module lives_controller
  import lives_pkg::*;
#(
  parameter int unsigned INIT_LIVES    = 3,
  parameter int unsigned MAX_LIVES     = 3,
  parameter int unsigned INVULN_FRAMES = 90,
  parameter int unsigned BLINK_FRAMES  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               newGame,
  input  logic               hit,
  input  logic               extraLife,
  output logic [LIVES_W-1:0] liveCount,
  output logic               invulnerable,
  output logic               blinkOn,
  output logic               lifeLost,
  output logic               gameOver
);

  localparam logic [LIVES_W-1:0]     INIT_L   = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0]     MAX_L    = LIVES_W'(MAX_LIVES);
  localparam logic [FRAME_CNT_W-1:0] INV_LOAD = FRAME_CNT_W'(INVULN_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] BLK_LOAD = FRAME_CNT_W'(BLINK_FRAMES);

  lives_state_t       state_d, state_q;
  logic [LIVES_W-1:0] lives_d, lives_q;
  logic               life_lost_d, life_lost_q;
  logic               blink_d, blink_q;

  logic                   frame_load, frame_dec, frame_zero, frame_last;
  logic                   blink_load, blink_dec, blink_zero, blink_last;
  logic [FRAME_CNT_W-1:0] frame_val, blink_val, frame_cnt, blink_cnt;

  frame_timer u_frame_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (frame_load),
    .load_val (frame_val),
    .dec      (frame_dec),
    .count    (frame_cnt),
    .zero     (frame_zero),
    .last     (frame_last)
  );

  frame_timer u_blink_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (blink_load),
    .load_val (blink_val),
    .dec      (blink_dec),
    .count    (blink_cnt),
    .zero     (blink_zero),
    .last     (blink_last)
  );

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    life_lost_d = 1'b0;
    blink_d     = blink_q;
    frame_load  = 1'b0;
    frame_val   = '0;
    frame_dec   = 1'b0;
    blink_load  = 1'b0;
    blink_val   = '0;
    blink_dec   = 1'b0;

    if (newGame) begin
      state_d    = ALIVE;
      lives_d    = INIT_L;
      blink_d    = 1'b1;
      frame_load = 1'b1;
      blink_load = 1'b1;
    end else begin
      unique case (state_q)
        ALIVE: begin
          if (hit) begin
            life_lost_d = 1'b1;
            if (lives_q > LIVES_W'(1)) begin
              lives_d    = lives_q - LIVES_W'(1);
              state_d    = INVULN;
              blink_d    = 1'b0;
              frame_load = 1'b1;
              frame_val  = INV_LOAD;
              blink_load = 1'b1;
              blink_val  = BLK_LOAD;
            end else begin
              lives_d = '0;
              state_d = GAME_OVER;
              blink_d = 1'b1;
            end
          end else if (extraLife && (lives_q < MAX_L)) begin
            lives_d = lives_q + LIVES_W'(1);
          end
        end

        INVULN: begin
          // Hits are ignored here, so a pickup is honoured alongside frame timing.
          if (extraLife && (lives_q < MAX_L)) begin
            lives_d = lives_q + LIVES_W'(1);
          end
          if (startOfFrame) begin
            frame_dec = 1'b1;
            if (frame_last || frame_zero) begin
              state_d = ALIVE;
              blink_d = 1'b1;
            end else if (blink_last || blink_zero) begin
              blink_load = 1'b1;
              blink_val  = BLK_LOAD;
              blink_d    = ~blink_q;
            end else begin
              blink_dec = 1'b1;
            end
          end
        end

        GAME_OVER: begin
          blink_d = 1'b1;
        end

        default: begin
          state_d = ALIVE;
          blink_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ALIVE;
      lives_q     <= INIT_L;
      life_lost_q <= 1'b0;
      blink_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      life_lost_q <= life_lost_d;
      blink_q     <= blink_d;
    end
  end

  assign liveCount    = lives_q;
  assign invulnerable = (state_q == INVULN);
  assign gameOver     = (state_q == GAME_OVER);
  assign blinkOn      = blink_q;
  assign lifeLost     = life_lost_q;

endmodule

// File: tb/tb_lives_controller.sv
// Randomised and directed bench for lives_controller with a queue-based scoreboard.
module tb_lives_controller;

  localparam int INIT  = 3;
  localparam int MAXL  = 3;
  localparam int INVF  = 90;
  localparam int BLKF  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       newGame = 1'b0;
  logic       hit = 1'b0;
  logic       extraLife = 1'b0;
  logic [1:0] liveCount;
  logic       invulnerable, blinkOn, lifeLost, gameOver;

  lives_controller #(
    .INIT_LIVES    (INIT),
    .MAX_LIVES     (MAXL),
    .INVULN_FRAMES (INVF),
    .BLINK_FRAMES  (BLKF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .newGame      (newGame),
    .hit          (hit),
    .extraLife    (extraLife),
    .liveCount    (liveCount),
    .invulnerable (invulnerable),
    .blinkOn      (blinkOn),
    .lifeLost     (lifeLost),
    .gameOver     (gameOver)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lives;
    bit inv;
    bit blink;
    bit lost;
    bit go;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 1'b0;

  // Reference model: lives as an integer, invulnerability as frames elapsed since the hit.
  int m_lives   = INIT;
  bit m_inv     = 1'b0;
  bit m_go      = 1'b0;
  bit m_lost    = 1'b0;
  int m_elapsed = 0;

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input bit r, input bit ng, input bit h, input bit el, input bit sof);
    m_lost = 1'b0;
    if (r || ng) begin
      m_lives = INIT; m_inv = 1'b0; m_go = 1'b0; m_elapsed = 0;
    end else if (m_go) begin
      // frozen until a new game
    end else if (m_inv) begin
      if (el) m_lives = min2(m_lives + 1, MAXL);
      if (sof) begin
        m_elapsed++;
        if (m_elapsed == INVF) m_inv = 1'b0;
      end
    end else if (h) begin
      m_lost = 1'b1;
      m_lives--;
      if (m_lives == 0) m_go = 1'b1;
      else begin m_inv = 1'b1; m_elapsed = 0; end
    end else if (el) begin
      m_lives = min2(m_lives + 1, MAXL);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.lives = m_lives;
    e.inv   = m_inv;
    e.lost  = m_lost;
    e.go    = m_go;
    e.blink = (!m_inv) ? 1'b1 : (((m_elapsed / BLKF) % 2) == 1);
    return e;
  endfunction

  task automatic cyc(input bit r, input bit ng, input bit h, input bit el, input bit sof);
    @(negedge clk);
    reset = r; newGame = ng; hit = h; extraLife = el; startOfFrame = sof;
    model_step(r, ng, h, el, sof);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // n frames, each 'gap' cycles long with startOfFrame on the last; hit held at level h.
  task automatic frames(input int n, input int gap, input bit h);
    for (int f = 0; f < n; f++) begin
      for (int g = 1; g < gap; g++) cyc(0, 0, h, 0, 0);
      cyc(0, 0, h, 0, 1);
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("liveCount",    int'(liveCount),    e.lives);
        chk("invulnerable", int'(invulnerable), int'(e.inv));
        chk("blinkOn",      int'(blinkOn),      int'(e.blink));
        chk("lifeLost",     int'(lifeLost),     int'(e.lost));
        chk("gameOver",     int'(gameOver),     int'(e.go));
      end
    end
  end

  initial begin : stimulus
    int budget;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(2);
    // Three spaced hits down to game over
    cyc(0, 0, 1, 0, 0); frames(95, 3, 0);
    cyc(0, 0, 1, 0, 0); frames(95, 3, 0);
    cyc(0, 0, 1, 0, 0); idle(3);
    // Game over ignores hit, pickup and frames; newGame restarts
    cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 1, 0); cyc(0, 0, 1, 1, 1);
    cyc(0, 1, 0, 0, 0); idle(2);
    // Second hit inside the window, then watch the blink pattern to expiry
    cyc(0, 0, 1, 0, 0); frames(10, 2, 0);
    cyc(0, 0, 1, 0, 0); frames(85, 2, 0); idle(2);
    // Pickups: saturation, then during invulnerability
    cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0); frames(5, 1, 0); cyc(0, 0, 0, 1, 0); frames(90, 1, 0);
    // Same-cycle hit and pickup at two lives
    cyc(0, 0, 1, 0, 0); frames(90, 1, 0);
    cyc(0, 0, 1, 1, 0); idle(2);
    // newGame mid-window
    frames(20, 1, 0); cyc(0, 1, 0, 0, 0); idle(2);
    // Held hit counted again on the first cycle after expiry
    frames(92, 1, 1); idle(2);
    // Reset mid-window with a same-edge hit, then a fresh hit
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); frames(50, 1, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0); idle(3);
    // Randomised traffic
    for (int i = 0; i < 6000; i++) begin
      cyc(($urandom_range(0, 1499) == 0),
          ($urandom_range(0, 399) == 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 2) == 0));
    end
    idle(2);
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    chk("scoreboard_drain", exp_q.size(), 0);
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
